// File: rtl/sys_issue.sv
// SYSTEM-instruction issue front end: holds one SYSTEM instruction, waits for older work
// to drain, then fires a single op pulse to the CSR/trap unit. Optional WFI state: SYS_WFI_EN.
module sys_issue #(
  parameter int XLEN         = 64,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] instr_pc,
  input  logic            pipe_busy,
  input  logic            kill,
  output logic            ecall_op,
  output logic            ebreak_op,
  output logic            mret_op,
  output logic            csrrw_op,
  output logic            csrrs_op,
  output logic            csrrc_op,
  output logic [11:0]     csr_addr,
  output logic [XLEN-1:0] imm,
  output logic            with_imm,
  output logic [XLEN-1:0] pc_out,
  output logic            illegal,
  output logic            flush,
`ifdef SYS_WFI_EN
  input  logic            irq_pending,
  output logic            wfi_active,
`endif
  output logic            sys_busy
);

  localparam int CW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_DRAIN, S_ISSUE, S_FLUSH, S_WFI} state_t;

  state_t          r_state, w_nstate;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_cnt;

  logic w_ecall, w_ebreak, w_mret, w_csrrw, w_csrrs, w_csrrc, w_illegal, w_trap;
`ifdef SYS_WFI_EN
  logic w_wfi;
`endif

  // Decode of the held word; wfi without the macro falls through as a NOP.
  always_comb begin
    w_ecall   = 1'b0;
    w_ebreak  = 1'b0;
    w_mret    = 1'b0;
    w_csrrw   = 1'b0;
    w_csrrs   = 1'b0;
    w_csrrc   = 1'b0;
    w_illegal = 1'b0;
`ifdef SYS_WFI_EN
    w_wfi     = 1'b0;
`endif
    if (r_instr[6:0] != 7'b1110011) begin
      w_illegal = 1'b1;
    end else begin
      case (r_instr[14:12])
        3'b001, 3'b101: w_csrrw = 1'b1;
        3'b010, 3'b110: w_csrrs = 1'b1;
        3'b011, 3'b111: w_csrrc = 1'b1;
        3'b000: begin
          case (r_instr)
            32'h0000_0073: w_ecall  = 1'b1;
            32'h0010_0073: w_ebreak = 1'b1;
            32'h3020_0073: w_mret   = 1'b1;
`ifdef SYS_WFI_EN
            32'h1050_0073: w_wfi    = 1'b1;
`else
            32'h1050_0073: ;
`endif
            default:       w_illegal = 1'b1;
          endcase
        end
        default: w_illegal = 1'b1;
      endcase
    end
  end

  assign w_trap = w_ecall | w_ebreak | w_mret | w_illegal;

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (instr_valid && !kill) w_nstate = S_DRAIN;
      S_DRAIN: begin
        if (kill)            w_nstate = S_IDLE;
        else if (!pipe_busy) w_nstate = S_ISSUE;
      end
      S_ISSUE: begin
        if (w_trap)     w_nstate = S_FLUSH;
`ifdef SYS_WFI_EN
        else if (w_wfi) w_nstate = S_WFI;
`endif
        else            w_nstate = S_IDLE;
      end
      S_FLUSH: if (r_cnt == '0) w_nstate = S_IDLE;
`ifdef SYS_WFI_EN
      S_WFI:   if (irq_pending || kill) w_nstate = S_IDLE;
`endif
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_instr  <= '0;
      r_pc     <= '0;
      r_cnt    <= '0;
      csr_addr <= '0;
      imm      <= '0;
      with_imm <= 1'b0;
      pc_out   <= '0;
    end else begin
      r_state <= w_nstate;
      if (r_state == S_IDLE && instr_valid && !kill) begin
        r_instr <= instr;
        r_pc    <= instr_pc;
      end
      // Operands land on entry to ISSUE so they are valid alongside the pulse, then hold.
      if (r_state == S_DRAIN && !kill && !pipe_busy) begin
        csr_addr <= r_instr[31:20];
        imm      <= {{(XLEN-5){1'b0}}, r_instr[19:15]};
        with_imm <= r_instr[14];
        pc_out   <= r_pc;
      end
      if (r_state == S_ISSUE && w_trap)
        r_cnt <= CW'(FLUSH_CYCLES - 1);
      else if (r_state == S_FLUSH && r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  wire w_issue = (r_state == S_ISSUE);

  assign ecall_op    = w_issue & w_ecall;
  assign ebreak_op   = w_issue & w_ebreak;
  assign mret_op     = w_issue & w_mret;
  assign csrrw_op    = w_issue & w_csrrw;
  assign csrrs_op    = w_issue & w_csrrs;
  assign csrrc_op    = w_issue & w_csrrc;
  assign illegal     = w_issue & w_illegal;
  assign flush       = (r_state == S_FLUSH);
  assign instr_ready = (r_state == S_IDLE);
  assign sys_busy    = (r_state != S_IDLE);
`ifdef SYS_WFI_EN
  assign wfi_active  = (r_state == S_WFI);
`endif

endmodule

// File: tb/tb_sys_issue.sv
// Directed bench for sys_issue: a transaction-level model checked every cycle plus literal spot checks.
module tb_sys_issue;
  localparam int XLEN = 64;
  localparam int FC   = 2;

  logic            clk = 1'b0, rst_n = 1'b0;
  logic            instr_valid = 1'b0, pipe_busy = 1'b0, kill = 1'b0;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] instr_pc = '0;
  logic            instr_ready, ecall_op, ebreak_op, mret_op, csrrw_op, csrrs_op, csrrc_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] imm, pc_out;
  logic            with_imm, illegal, flush, sys_busy;
`ifdef SYS_WFI_EN
  logic            irq_pending = 1'b0;
  logic            wfi_active;
`endif

  sys_issue #(.XLEN(XLEN), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .pipe_busy(pipe_busy), .kill(kill),
    .ecall_op(ecall_op), .ebreak_op(ebreak_op), .mret_op(mret_op), .csrrw_op(csrrw_op),
    .csrrs_op(csrrs_op), .csrrc_op(csrrc_op), .csr_addr(csr_addr), .imm(imm),
    .with_imm(with_imm), .pc_out(pc_out), .illegal(illegal), .flush(flush),
`ifdef SYS_WFI_EN
    .irq_pending(irq_pending), .wfi_active(wfi_active),
`endif
    .sys_busy(sys_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // pulse vector: {illegal, csrrc, csrrs, csrrw, mret, ebreak, ecall}
  wire [6:0] pv = {illegal, csrrc_op, csrrs_op, csrrw_op, mret_op, ebreak_op, ecall_op};

  // Instruction class: 0 illegal, 1 ecall, 2 ebreak, 3 mret, 4 csrrw, 5 csrrs, 6 csrrc, 7 wfi
  function automatic int kind(input logic [31:0] w);
    if (w[6:0] != 7'h73) return 0;
    case (w[14:12])
      3'd1, 3'd5: return 4;
      3'd2, 3'd6: return 5;
      3'd3, 3'd7: return 6;
      3'd0: begin
        if (w == 32'h0000_0073) return 1;
        if (w == 32'h0010_0073) return 2;
        if (w == 32'h3020_0073) return 3;
        if (w == 32'h1050_0073) return 7;
        return 0;
      end
      default: return 0;
    endcase
  endfunction

  // Model: a held instruction, an issue-this-cycle flag, remaining flush cycles, a wfi wait.
  bit              m_held = 0, m_issue = 0, m_wfi = 0;
  int              m_flush = 0;
  logic [31:0]     m_ins = '0;
  logic [XLEN-1:0] m_pc = '0;
  logic [11:0]     e_csr = '0;
  logic [XLEN-1:0] e_imm = '0, e_pc = '0;
  logic            e_wi = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_held <= 0; m_issue <= 0; m_wfi <= 0; m_flush <= 0;
      e_csr <= '0; e_imm <= '0; e_pc <= '0; e_wi <= 1'b0;
    end else if (m_issue) begin
      m_issue <= 0;
      if (kind(m_ins) <= 3) m_flush <= FC;
`ifdef SYS_WFI_EN
      else if (kind(m_ins) == 7) m_wfi <= 1;
`endif
    end else if (m_flush > 0) begin
      m_flush <= m_flush - 1;
    end else if (m_wfi) begin
`ifdef SYS_WFI_EN
      if (irq_pending || kill) m_wfi <= 0;
`else
      m_wfi <= 0;
`endif
    end else if (m_held) begin
      if (kill) m_held <= 0;
      else if (!pipe_busy) begin
        m_held  <= 0;
        m_issue <= 1;
        e_csr   <= m_ins[31:20];
        e_imm   <= XLEN'(m_ins[19:15]);
        e_wi    <= m_ins[14];
        e_pc    <= m_pc;
      end
    end else if (instr_valid && !kill) begin
      m_held <= 1;
      m_ins  <= instr;
      m_pc   <= instr_pc;
    end
  end

  always @(negedge clk) begin
    logic [6:0] exp_pv;
    logic       idle;
    exp_pv = '0;
    if (m_issue) begin
      case (kind(m_ins))
        0: exp_pv = 7'b1000000;
        1: exp_pv = 7'b0000001;
        2: exp_pv = 7'b0000010;
        3: exp_pv = 7'b0000100;
        4: exp_pv = 7'b0001000;
        5: exp_pv = 7'b0010000;
        6: exp_pv = 7'b0100000;
        default: exp_pv = '0;
      endcase
    end
    idle = !(m_held || m_issue || m_wfi || m_flush > 0);
    chk("cyc_pulses", 64'(pv), 64'(exp_pv));
    chk("cyc_ready", 64'(instr_ready), 64'(idle));
    chk("cyc_busy", 64'(sys_busy), 64'(!idle));
    chk("cyc_flush", 64'(flush), 64'(m_flush > 0));
    chk("cyc_csr", 64'(csr_addr), 64'(e_csr));
    chk("cyc_imm", imm, e_imm);
    chk("cyc_wimm", 64'(with_imm), 64'(e_wi));
    chk("cyc_pc", pc_out, e_pc);
`ifdef SYS_WFI_EN
    chk("cyc_wfi", 64'(wfi_active), 64'(m_wfi));
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns one region after the accepting edge (block in DRAIN).
  task automatic offer(input logic [31:0] w, input logic [XLEN-1:0] pc);
    instr = w; instr_pc = pc; instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  logic [31:0] trap_w [5] = '{32'h0000_0073, 32'h3020_0073, 32'h0000_4073, 32'h0020_0073, 32'h0010_0073};
  logic [6:0]  trap_p [5] = '{7'b0000001, 7'b0000100, 7'b1000000, 7'b1000000, 7'b0000010};

  initial begin
    int n;
    #1;
    chk("rst_ready", 64'(instr_ready), 64'd1);
    chk("rst_busy", 64'(sys_busy), 64'd0);
    chk("rst_pulses", 64'(pv), 64'd0);
    chk("rst_pc", pc_out, 64'd0);
    step();
    rst_n = 1'b1;
    step();

    // csrrw mscratch, x2
    offer(32'h3401_1073, 64'h8000_0010);
    chk("csrrw_drain", 64'(pv), 64'd0);
    step();
    chk("csrrw_pulse", 64'(pv), 64'b0001000);
    chk("csrrw_csr", 64'(csr_addr), 64'h340);
    chk("csrrw_wimm", 64'(with_imm), 64'd0);
    chk("csrrw_imm", imm, 64'd2);
    chk("csrrw_pc", pc_out, 64'h8000_0010);
    step();
    chk("csrrw_idle", 64'(instr_ready), 64'd1);
    chk("csrrw_noflush", 64'(flush), 64'd0);
    chk("csrrw_hold_pc", pc_out, 64'h8000_0010);

    // csrrsi mtvec, 5 with older work still in flight
    pipe_busy = 1'b1;
    offer(32'h3052_E073, 64'h8000_0020);
    for (int i = 0; i < 3; i++) begin
      chk("csrrs_wait", 64'(pv), 64'd0);
      step();
    end
    pipe_busy = 1'b0;
    step();
    chk("csrrs_pulse", 64'(pv), 64'b0010000);
    chk("csrrs_imm", imm, 64'd5);
    chk("csrrs_wimm", 64'(with_imm), 64'd1);
    chk("csrrs_csr", 64'(csr_addr), 64'h305);
    step();

    // trap-class and illegal words: pulse then an FC-cycle flush window
    for (int t = 0; t < 5; t++) begin
      offer(trap_w[t], 64'h100 + 64'(t));
      step();
      chk("trap_pulse", 64'(pv), 64'(trap_p[t]));
      for (int f = 0; f < FC; f++) begin
        step();
        chk("trap_flush", 64'(flush), 64'd1);
        chk("trap_notready", 64'(instr_ready), 64'd0);
      end
      step();
      chk("trap_end", 64'(flush), 64'd0);
      chk("trap_ready", 64'(instr_ready), 64'd1);
    end

    // kill in DRAIN wins over pipe_busy falling the same cycle
    pipe_busy = 1'b1;
    offer(32'h3401_3073, 64'h200);
    step();
    kill = 1'b1; pipe_busy = 1'b0;
    step();
    kill = 1'b0;
    chk("kill_idle", 64'(instr_ready), 64'd1);
    chk("kill_nopulse", 64'(pv), 64'd0);
    step();
    chk("kill_nopulse2", 64'(pv), 64'd0);

    // valid together with kill in IDLE is not accepted
    instr = 32'h3401_1073; instr_valid = 1'b1; kill = 1'b1;
    step();
    instr_valid = 1'b0; kill = 1'b0;
    chk("killidle_ready", 64'(instr_ready), 64'd1);
    step();

    // back-to-back csr accepts every third cycle
    n = 0;
    instr = 32'h3401_1073; instr_pc = 64'h300; instr_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (csrrw_op) n++;
    end
    instr_valid = 1'b0;
    chk("b2b_count", 64'(n), 64'd3);
    step();
    step();

`ifdef SYS_WFI_EN
    irq_pending = 1'b0;
    offer(32'h1050_0073, 64'h400);
    step();
    chk("wfi_issue", 64'(pv), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("wfi_active", 64'(wfi_active), 64'd1);
    end
    irq_pending = 1'b1;
    step();
    irq_pending = 1'b0;
    chk("wfi_exit", 64'(instr_ready), 64'd1);
    chk("wfi_off", 64'(wfi_active), 64'd0);
`else
    offer(32'h1050_0073, 64'h400);
    step();
    chk("nop_issue", 64'(pv), 64'd0);
    chk("nop_busy", 64'(sys_busy), 64'd1);
    step();
    chk("nop_idle", 64'(instr_ready), 64'd1);
    chk("nop_noflush", 64'(flush), 64'd0);
`endif
    step();

    // async reset while draining
    pipe_busy = 1'b1;
    offer(32'h3051_1073, 64'h500);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(instr_ready), 64'd1);
    chk("arst_busy", 64'(sys_busy), 64'd0);
    chk("arst_csr", 64'(csr_addr), 64'd0);
    chk("arst_pc", pc_out, 64'd0);
    chk("arst_imm", imm, 64'd0);
    step();
    rst_n = 1'b1;
    pipe_busy = 1'b0;
    step();
    chk("arst_nopulse", 64'(pv), 64'd0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
